leaf_out_packetizer: RTL and testbench

Output-side packetizer between a leaf's user kernel output streams and the BFT-facing packet port. It accepts up to NUM_OUT_PORTS 32-bit valid/ack streams from the user kernel, buffers each stream in a 2-entry skid buffer, and arbitrates round-robin among them. Each granted word becomes a 49-bit BFT packet carrying destination leaf, destination port and write address. Per-port credit counters track the free space in the destination input BRAM, so no port can overrun its remote receiver.

---
 rtl/leaf_out_packetizer.sv | 191 +++++++++++++++++++
 tb/tb_leaf_out_packetizer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_packetizer.sv
// leaf_out_packetizer: user output streams -> BFT packets.
// Per-port skid buffers, credit flow control, round-robin issue.
module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 5,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] cfg_dest,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic                                  out_ready,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);

  localparam int N  = NUM_OUT_PORTS;
  localparam int DW = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CW = NUM_ADDR_BITS + 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [CW-1:0] CRED_MAX =
    {1'b1, {NUM_ADDR_BITS{1'b0}}};
  localparam logic [CW:0] CRED_ADD =
    (CW + 1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [NUM_PORT_BITS-1:0] PORT_LIM =
    NUM_PORT_BITS'(N);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;

  logic [DW-1:0]            dest     [N];
  logic [PAYLOAD_BITS-1:0]  din_w    [N];
  logic [PAYLOAD_BITS-1:0]  mem      [N][2];
  logic                     wp       [N];
  logic                     rp       [N];
  logic [1:0]               cnt      [N];
  logic [1:0]               cnt_nxt  [N];
  logic [CW-1:0]            credit   [N];
  logic [CW-1:0]            cred_nxt [N];
  logic [CW:0]              cred_sum [N];
  logic [NUM_ADDR_BITS-1:0] addr     [N];

  logic [N-1:0]  ack_r;
  logic [N-1:0]  wr;
  logic [N-1:0]  rd;
  logic [N-1:0]  ret;
  logic [N-1:0]  elig;
  logic [PW-1:0] last_grant;
  logic [PW-1:0] grant;
  logic [PW-1:0] idx;
  logic          grant_vld;
  logic          can_load;
  logic          issue;
  logic          drain;

  ostate_t                state;
  ostate_t                state_nxt;
  logic [PACKET_BITS-1:0] out_pkt;
  logic [PACKET_BITS-1:0] pkt_nxt;

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign dest[g]  = cfg_dest[g*DW +: DW];
    assign din_w[g] =
      din_leaf_user2interface[g*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  assign ack_interface2user = ack_r;

  // Per-port transfer, credit-return and eligibility flags.
  always_comb begin
    wr   = '0;
    ret  = '0;
    elig = '0;
    for (int i = 0; i < N; i++) begin
      wr[i]   = vld_user2interface[i] & ack_r[i];
      ret[i]  = credit_vld && (credit_port < PORT_LIM) &&
                (credit_port == NUM_PORT_BITS'(i));
      elig[i] = (cnt[i] != 2'd0) && (credit[i] != '0);
    end
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = last_grant;
    for (int k = 0; k < N; k++) begin
      idx = (idx == LAST) ? '0 : idx + 1'b1;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  assign can_load = !resend && ((state == EMPTY) || out_ready);
  assign issue    = can_load && grant_vld;
  assign drain    = can_load && (state == FULL) && !grant_vld;

  assign pkt_nxt = {1'b1, dest[grant], addr[grant],
                    mem[grant][rp[grant]]};

  // Skid occupancy and saturating credit next-state per port.
  always_comb begin
    rd = '0;
    for (int i = 0; i < N; i++) begin
      rd[i]       = issue && (grant == PW'(i));
      cnt_nxt[i]  = cnt[i];
      if (wr[i] && !rd[i]) cnt_nxt[i] = cnt[i] + 2'd1;
      if (!wr[i] && rd[i]) cnt_nxt[i] = cnt[i] - 2'd1;
      cred_sum[i] = {1'b0, credit[i]}
                  + (ret[i] ? CRED_ADD : '0)
                  - (CW + 1)'(rd[i]);
      cred_nxt[i] = (cred_sum[i] > {1'b0, CRED_MAX}) ?
                    CRED_MAX : cred_sum[i][CW-1:0];
    end
  end

  // Per-port skid pointers, ack, credits and write addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i]    <= 2'd0;
        wp[i]     <= 1'b0;
        rp[i]     <= 1'b0;
        credit[i] <= CRED_MAX;
        addr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt[i]    <= cnt_nxt[i];
        ack_r[i]  <= (cnt_nxt[i] != 2'd2);
        credit[i] <= cred_nxt[i];
        if (wr[i]) wp[i] <= ~wp[i];
        if (rd[i]) begin
          rp[i]   <= ~rp[i];
          addr[i] <= addr[i] + 1'b1;
        end
      end
    end
  end

  // Skid storage; contents are qualified by the occupancy count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (wr[i]) mem[i][wp[i]] <= din_w[i];
    end
  end

  // Round-robin pointer moves only when a packet is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant <= LAST;
    else if (issue) last_grant <= grant;
  end

  // Output register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else state <= state_nxt;
  end

  // Output register next state.
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      issue:   state_nxt = FULL;
      drain:   state_nxt = EMPTY;
      default: state_nxt = state;
    endcase
  end

  // Output packet register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_pkt <= '0;
    else if (issue) out_pkt <= pkt_nxt;
  end

  assign dout_leaf_interface2bft =
    ((state == FULL) && !resend) ? out_pkt : '0;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// tb_leaf_out_packetizer: randomized traffic with per-port
// scoreboard queues and directed credit/stall scenarios.
module tb_leaf_out_packetizer;

  localparam int N  = 5;
  localparam int PB = 32;
  localparam int DW = 9;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N*PB-1:0] din;
  logic [N-1:0]    vld;
  logic [N-1:0]    ack;
  logic [N*DW-1:0] cfg;
  logic            credit_vld;
  logic [3:0]      credit_port;
  logic            out_ready;
  logic            resend;
  logic [48:0]     dout;

  leaf_out_packetizer dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_dest                (cfg),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .out_ready               (out_ready),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] expq [N][$];
  logic [6:0]  addr_m [N];
  int          pkts [N];
  int          acc [N];
  int          rr_prev;
  bit          rr_on;
  int          mp;
  logic [48:0] me;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int total();
    int s = 0;
    for (int i = 0; i < N; i++) s += pkts[i];
    return s;
  endfunction

  task automatic rand_din();
    for (int i = 0; i < N; i++) din[i*PB +: PB] = $urandom;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      expq[i].delete();
      addr_m[i] = 7'd0;
      pkts[i]   = 0;
      acc[i]    = 0;
    end
    rr_prev = N - 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n    = 1'b0;
    vld        = '0;
    credit_vld = 1'b0;
    resend     = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk); #1;
      rand_din();
    end
  endtask

  task automatic send_n(int p, int n);
    int c = 0;
    int guard = 0;
    vld[p] = 1'b1;
    rand_din();
    while (c < n && guard < 5000) begin
      @(negedge clk);
      if (ack[p]) c++;
      @(posedge clk); #1;
      if (c == n) vld[p] = 1'b0;
      else rand_din();
      guard++;
    end
    vld[p] = 1'b0;
    chk("send_n_done", c, n);
  endtask

  // Credit return landing on the same edge as a port-2 issue.
  task automatic coincide(int pre);
    int more;
    more = 128 - pre - 1 + 64;
    if (more > 128) more = 128;
    do_reset();
    send_n(2, pre);
    cycles(10);
    chk("pre_sent", pkts[2], pre);
    vld[2] = 1'b1;
    rand_din();
    @(posedge clk); #1;
    vld[2]      = 1'b0;
    credit_vld  = 1'b1;
    credit_port = 4'd2;
    @(posedge clk); #1;
    credit_vld = 1'b0;
    vld[2]     = 1'b1;
    cycles(220);
    chk("coincide_total", pkts[2], pre + 1 + more);
    vld[2] = 1'b0;
  endtask

  // Record every accepted user word as an expected payload.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (vld[i] && ack[i]) begin
          expq[i].push_back(din[i*PB +: PB]);
          acc[i]++;
        end
      end
    end
  end

  // Check every packet that the downstream consumes.
  always @(negedge clk) begin
    if (reset_n && out_ready && !resend && dout[48]) begin
      mp = int'(dout[47:43]) - 3;
      if (mp < 0 || mp >= N) begin
        tests++;
        fails++;
        $display("FAIL decode: leaf %0d got, 3..7 required",
                 dout[47:43]);
      end else if (expq[mp].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected: port %0d pkt %0h got, none required",
                 mp, dout);
      end else begin
        me = {1'b1, cfg[mp*DW +: DW], addr_m[mp],
              expq[mp].pop_front()};
        chk("packet", 64'(dout), 64'(me));
        if (rr_on) chk("rr_order", mp, (rr_prev + 1) % N);
        addr_m[mp] = addr_m[mp] + 7'd1;
        pkts[mp]++;
        rr_prev = mp;
      end
    end
  end

  logic [48:0] exp_pkt;
  int          base;

  initial begin
    reset_n     = 1'b0;
    vld         = '0;
    din         = '0;
    credit_vld  = 1'b0;
    credit_port = 4'd0;
    out_ready   = 1'b1;
    resend      = 1'b0;
    rr_on       = 1'b0;
    for (int i = 0; i < N; i++)
      cfg[i*DW +: DW] = {5'(3 + i), 4'(2 + i)};
    clear_model();

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ack_before_edge", 64'(ack), 64'd0);
    @(posedge clk); #1;
    chk("ack_after_edge", 64'(ack), 64'h1f);

    // single port latency
    din[31:0] = 32'hDEADBEEF;
    vld[0]    = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk("latency_early", 64'(dout), 64'd0);
    @(negedge clk);
    exp_pkt = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
    chk("single_pkt", 64'(dout), 64'(exp_pkt));
    cycles(5);

    // all ports busy: round robin and full throughput
    do_reset();
    rr_on = 1'b1;
    vld   = '1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      rand_din();
      if (c == 10) base = total();
    end
    chk("throughput", total() - base, 29);
    vld   = '0;
    rr_on = 1'b0;
    cycles(15);
    for (int i = 0; i < N; i++)
      chk("rr_drained", expq[i].size(), 0);

    // port 1 credit exhaustion and release
    do_reset();
    vld[1] = 1'b1;
    cycles(200);
    chk("cred_stall_pkts", pkts[1], 128);
    chk("cred_stall_acc", acc[1], 130);
    chk("cred_stall_ack", 64'(ack[1]), 64'd0);
    credit_vld  = 1'b1;
    credit_port = 4'd7;
    @(posedge clk); #1;
    credit_port = 4'd5;
    @(posedge clk); #1;
    credit_vld = 1'b0;
    cycles(20);
    chk("bad_port_ignored", pkts[1], 128);
    credit_vld  = 1'b1;
    credit_port = 4'd1;
    @(posedge clk); #1;
    credit_vld = 1'b0;
    cycles(150);
    chk("cred_release", pkts[1], 192);
    chk("cred_release_acc", acc[1], 194);
    vld[1] = 1'b0;

    // coincident return and issue
    coincide(28);
    coincide(118);

    // out_ready stall then resend window
    do_reset();
    out_ready = 1'b0;
    vld[0]    = 1'b1;
    vld[3]    = 1'b1;
    cycles(4);
    vld = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_pkt = {1'b1, cfg[8:0], 7'd0, expq[0][0]};
      chk("stall_hold", 64'(dout), 64'(exp_pkt));
      @(posedge clk); #1;
    end
    resend    = 1'b1;
    out_ready = 1'b1;
    vld[4]    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("resend_zero", 64'(dout), 64'd0);
      @(posedge clk); #1;
      vld[4] = 1'b0;
    end
    resend = 1'b0;
    cycles(15);
    chk("after_stall_p0", pkts[0], 3);
    chk("after_stall_p3", pkts[3], 2);
    chk("resend_skid_acc", acc[4], 1);
    chk("resend_skid_pkt", pkts[4], 1);

    // reset with a packet held in the output register
    out_ready = 1'b0;
    vld[4]    = 1'b1;
    cycles(2);
    vld[4] = 1'b0;
    cycles(3);
    chk("held_valid", 64'(dout[48]), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_dout", 64'(dout), 64'd0);
    clear_model();
    @(posedge clk); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    cycles(10);
    chk("discarded", total(), 0);
    vld[4] = 1'b1;
    rand_din();
    @(posedge clk); #1;
    vld[4] = 1'b0;
    cycles(6);
    chk("post_rst_pkt", pkts[4], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
